// File: rtl/logic_unit_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : logic_unit_pipe_pkg
// Purpose : Shared definitions for the pipelined logic unit: operation codes,
//           field widths and flag bundle layout.
// Ports   : (package, no ports)
// Revision: 1.0  initial release
// ============================================================================
package logic_unit_pipe_pkg;

   // Width of the operation select field.
   localparam int OP_W   = 3;

   // Number of status flags carried alongside each result (zero, ones, parity).
   localparam int FLAG_W = 3;

   // Operation encoding. NOT and PASS look only at operand a.
   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_NOT  = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XOR  = 3'd5,
      OP_XNOR = 3'd6,
      OP_PASS = 3'd7
   } lu_op_e;

   // Result flag bundle, packed in the order it travels through stage 2.
   typedef struct packed {
      logic zero;
      logic ones;
      logic par;
   } lu_flags_t;

endpackage : logic_unit_pipe_pkg
`default_nettype wire

// File: rtl/lu_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module  : lu_pipe_stage
// Purpose : One valid/ready register slice. Captures in_data when the
//           upstream beat is accepted, holds it stable until the downstream
//           side takes it. No skid buffer: in_ready is combinational from
//           out_ready, so a full slice that is being drained can reload in
//           the same cycle.
// Ports   : clk, rst        - clock, asynchronous active-high reset
//           in_valid/ready  - upstream handshake
//           in_data         - upstream payload (DW bits)
//           out_valid/ready - downstream handshake
//           out_data        - registered payload (DW bits)
// Revision: 1.0  initial release
// ============================================================================
module lu_pipe_stage #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);

   logic          valid_q;
   logic          valid_d;
   logic [DW-1:0] data_q;
   logic [DW-1:0] data_d;
   logic          w_load;

   // Empty slices always accept; full ones only when they are being drained.
   assign in_ready = ~valid_q | out_ready;
   assign w_load   = in_valid & in_ready;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (w_load) begin
         valid_d = 1'b1;
         data_d  = in_data;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule : lu_pipe_stage
`default_nettype wire

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module  : logic_unit_pipe
// Purpose : Two-stage pipelined bitwise logic unit. Stage 1 registers the
//           request; the result, its flags and the accumulator update are
//           computed on the stage 1 -> stage 2 transfer. Full throughput,
//           valid/ready on both sides.
// Ports   : clk, rst            - clock, asynchronous active-high reset
//           in_valid/in_ready   - request handshake
//           in_op               - operation select (see lu_op_e)
//           in_acc              - 1: operand b is the accumulator
//           in_a, in_b          - operands (WIDTH bits)
//           acc_clr             - synchronous accumulator clear
//           out_valid/out_ready - result handshake
//           out_data            - result (WIDTH bits)
//           out_zero/ones/par   - result == 0, result all ones, XOR of result
//           acc_q               - current accumulator value
// Revision: 1.0  initial release
// ============================================================================
module logic_unit_pipe
   import logic_unit_pipe_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_op,
   input  logic             in_acc,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_zero,
   output logic             out_ones,
   output logic             out_par,
   output logic [WIDTH-1:0] acc_q
);

   localparam int S1_W = OP_W + 1 + 2 * WIDTH;
   localparam int S2_W = WIDTH + FLAG_W;

   // ------------------------------------------------------------------
   // Stage 1: request register {op, acc, a, b}
   // ------------------------------------------------------------------
   logic [S1_W-1:0]  w_s1_in;
   logic [S1_W-1:0]  w_s1_out;
   logic             w_s1_valid;
   logic             w_s2_ready;

   assign w_s1_in = {in_op, in_acc, in_a, in_b};

   lu_pipe_stage #(
      .DW (S1_W)
   ) u_s1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (w_s1_in),
      .out_valid (w_s1_valid),
      .out_ready (w_s2_ready),
      .out_data  (w_s1_out)
   );

   logic [OP_W-1:0]  w_s1_op;
   logic             w_s1_acc;
   logic [WIDTH-1:0] w_s1_a;
   logic [WIDTH-1:0] w_s1_b;

   assign {w_s1_op, w_s1_acc, w_s1_a, w_s1_b} = w_s1_out;

   // ------------------------------------------------------------------
   // Result and flag logic between the stages
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] accum_q;
   logic [WIDTH-1:0] accum_d;
   logic [WIDTH-1:0] w_opb;
   logic [WIDTH-1:0] w_result;
   lu_flags_t        w_flags;

   // Accumulating beats read the live accumulator, so a beat that directly
   // follows another accumulating beat sees its predecessor's result.
   assign w_opb = w_s1_acc ? accum_q : w_s1_b;

   always_comb begin
      w_result = '0;
      case (lu_op_e'(w_s1_op))
         OP_AND  : w_result =   w_s1_a & w_opb;
         OP_OR   : w_result =   w_s1_a | w_opb;
         OP_NOT  : w_result =  ~w_s1_a;
         OP_NAND : w_result = ~(w_s1_a & w_opb);
         OP_NOR  : w_result = ~(w_s1_a | w_opb);
         OP_XOR  : w_result =   w_s1_a ^ w_opb;
         OP_XNOR : w_result = ~(w_s1_a ^ w_opb);
         OP_PASS : w_result =   w_s1_a;
         default : w_result =   w_s1_a;
      endcase
   end

   always_comb begin
      w_flags.zero = ~|w_result;
      w_flags.ones =  &w_result;
      w_flags.par  =  ^w_result;
   end

   // ------------------------------------------------------------------
   // Accumulator
   // ------------------------------------------------------------------
   logic w_xfer;

   assign w_xfer = w_s1_valid & w_s2_ready;

   // A clear arriving with an accumulating transfer still lets that
   // transfer compute from the old value, but the clear decides what the
   // accumulator holds afterwards.
   always_comb begin
      accum_d = accum_q;
      if (acc_clr) begin
         accum_d = '0;
      end else if (w_xfer && w_s1_acc) begin
         accum_d = w_result;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         accum_q <= '0;
      end else begin
         accum_q <= accum_d;
      end
   end

   assign acc_q = accum_q;

   // ------------------------------------------------------------------
   // Stage 2: result register {data, flags}
   // ------------------------------------------------------------------
   logic [S2_W-1:0] w_s2_in;
   logic [S2_W-1:0] w_s2_out;
   lu_flags_t       w_out_flags;

   assign w_s2_in = {w_result, w_flags};

   lu_pipe_stage #(
      .DW (S2_W)
   ) u_s2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (w_s1_valid),
      .in_ready  (w_s2_ready),
      .in_data   (w_s2_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (w_s2_out)
   );

   assign {out_data, w_out_flags} = w_s2_out;
   assign out_zero = w_out_flags.zero;
   assign out_ones = w_out_flags.ones;
   assign out_par  = w_out_flags.par;

endmodule : logic_unit_pipe
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_logic_unit_pipe
// Purpose : Self-checking bench for logic_unit_pipe (WIDTH = 8). Directed
//           scenarios followed by a randomized stream checked against a
//           queue-based reference model.
// Revision: 1.0  initial release
// ============================================================================
module tb_logic_unit_pipe;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   in_op;
   logic         in_acc;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         acc_clr;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_zero;
   logic         out_ones;
   logic         out_par;
   logic [W-1:0] acc_q;

   int checks = 0;
   int errors = 0;
   int ecount = 0;

   logic_unit_pipe #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_acc    (in_acc),
      .in_a      (in_a),
      .in_b      (in_b),
      .acc_clr   (acc_clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_zero  (out_zero),
      .out_ones  (out_ones),
      .out_par   (out_par),
      .acc_q     (acc_q)
   );

   always #5 clk = ~clk;
   always @(posedge clk) ecount <= ecount + 1;

   // Reference: the eight bitwise operations straight from their definitions.
   function automatic logic [W-1:0] ref_logic(input logic [2:0] op,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return ~a;
         3'd3:    return ~(a & b);
         3'd4:    return ~(a | b);
         3'd5:    return a ^ b;
         3'd6:    return ~(a ^ b);
         default: return a;
      endcase
   endfunction

   task automatic set_beat(input logic v, input logic [2:0] op, input logic acc,
                           input logic [W-1:0] a, input logic [W-1:0] b);
      in_valid = v;
      in_op    = op;
      in_acc   = acc;
      in_a     = a;
      in_b     = b;
   endtask

   // ---------------------------------------------------------------
   task automatic test_reset();
      set_beat(1'b0, 3'd0, 1'b0, '0, '0);
      acc_clr   = 1'b0;
      out_ready = 1'b1;
      rst       = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({out_valid, out_data, out_zero, out_ones, out_par, acc_q, in_ready} !==
          {1'b0, 8'h00, 3'b000, 8'h00, 1'b1}) begin
         errors++;
         $display("FAIL reset_state got v=%b d=%h z=%b o=%b p=%b acc=%h rdy=%b want v=0 d=00 flags=000 acc=00 rdy=1",
                  out_valid, out_data, out_zero, out_ones, out_par, acc_q, in_ready);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   // ---------------------------------------------------------------
   task automatic test_op_sweep();
      logic [W-1:0] exp_t [8] = '{8'h48, 8'hDE, 8'h35, 8'hB7, 8'h21, 8'h96, 8'h69, 8'hCA};
      logic [W-1:0] r;
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (k >= 2) begin
            r = exp_t[k-2];
            checks++;
            if ({out_valid, out_data, out_zero, out_ones, out_par} !==
                {1'b1, r, (r == 8'h00), (r == 8'hFF), ^r}) begin
               errors++;
               $display("FAIL op_sweep op=%0d got v=%b d=%h z%b o%b p%b want v=1 d=%h",
                        k-2, out_valid, out_data, out_zero, out_ones, out_par, r);
            end
         end
         if (k < 8) set_beat(1'b1, 3'(k), 1'b0, 8'hCA, 8'h5C);
         else       set_beat(1'b0, 3'd0, 1'b0, '0, '0);
         @(negedge clk);
      end
   endtask

   // ---------------------------------------------------------------
   task automatic test_flags();
      logic [W-1:0] exp_d [3] = '{8'h00, 8'hFF, 8'h01};
      logic [2:0]   exp_f [3] = '{3'b100, 3'b010, 3'b001};
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (k >= 2) begin
            checks++;
            if ({out_valid, out_data, out_zero, out_ones, out_par} !==
                {1'b1, exp_d[k-2], exp_f[k-2]}) begin
               errors++;
               $display("FAIL flags idx=%0d got v=%b d=%h zop=%b%b%b want v=1 d=%h zop=%b",
                        k-2, out_valid, out_data, out_zero, out_ones, out_par, exp_d[k-2], exp_f[k-2]);
            end
         end
         case (k)
            0:       set_beat(1'b1, 3'd0, 1'b0, 8'hF0, 8'h0F);
            1:       set_beat(1'b1, 3'd1, 1'b0, 8'hF0, 8'h0F);
            2:       set_beat(1'b1, 3'd7, 1'b0, 8'h01, 8'hFF);
            default: set_beat(1'b0, 3'd0, 1'b0, '0, '0);
         endcase
         @(negedge clk);
      end
   endtask

   // ---------------------------------------------------------------
   task automatic test_accumulate();
      logic [W-1:0] a_t   [3] = '{8'h11, 8'h22, 8'h44};
      logic [W-1:0] exp_t [3] = '{8'h11, 8'h33, 8'h77};
      out_ready = 1'b1;
      acc_clr   = 1'b1;
      @(negedge clk);
      acc_clr   = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k >= 2) begin
            checks++;
            if ({out_valid, out_data} !== {1'b1, exp_t[k-2]}) begin
               errors++;
               $display("FAIL accumulate idx=%0d got v=%b d=%h want v=1 d=%h",
                        k-2, out_valid, out_data, exp_t[k-2]);
            end
         end
         if (k < 3) set_beat(1'b1, 3'd5, 1'b1, a_t[k], 8'($urandom));
         else       set_beat(1'b0, 3'd0, 1'b0, '0, '0);
         @(negedge clk);
      end
      checks++;
      if (acc_q !== 8'h77) begin
         errors++;
         $display("FAIL accumulate_final got acc=%h want 77", acc_q);
      end
   endtask

   // ---------------------------------------------------------------
   task automatic test_back_pressure();
      logic [2:0]   op_t [3] = '{3'd1, 3'd5, 3'd3};
      logic [W-1:0] a_t  [3] = '{8'h3C, 8'hA5, 8'h0F};
      logic [W-1:0] b_t  [3] = '{8'h81, 8'h5A, 8'hF3};
      logic [W-1:0] exp_t[3];
      int  n_in  = 0;
      int  n_out = 0;
      logic take;
      for (int k = 0; k < 3; k++) exp_t[k] = ref_logic(op_t[k], a_t[k], b_t[k]);
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (n_in < 3) set_beat(1'b1, op_t[n_in], 1'b0, a_t[n_in], b_t[n_in]);
         else          set_beat(1'b0, 3'd0, 1'b0, '0, '0);
         #1;
         checks++;
         if (in_ready !== (c < 2)) begin
            errors++;
            $display("FAIL bp_in_ready cyc=%0d got %b want %b", c, in_ready, (c < 2));
         end
         if (c >= 2) begin
            checks++;
            if ({out_valid, out_data} !== {1'b1, exp_t[0]}) begin
               errors++;
               $display("FAIL bp_stall_hold cyc=%0d got v=%b d=%h want v=1 d=%h",
                        c, out_valid, out_data, exp_t[0]);
            end
         end
         take = in_valid && in_ready;
         @(negedge clk);
         if (take) n_in++;
      end
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (n_in < 3) set_beat(1'b1, op_t[n_in], 1'b0, a_t[n_in], b_t[n_in]);
         else          set_beat(1'b0, 3'd0, 1'b0, '0, '0);
         #1;
         take = in_valid && in_ready;
         if (out_valid) begin
            checks++;
            if (n_out >= 3) begin
               errors++;
               $display("FAIL bp_extra_beat got d=%h want no beat", out_data);
            end else if (out_data !== exp_t[n_out]) begin
               errors++;
               $display("FAIL bp_order idx=%0d got d=%h want %h", n_out, out_data, exp_t[n_out]);
            end
            n_out++;
         end
         @(negedge clk);
         if (take) n_in++;
      end
      checks++;
      if (n_out != 3) begin
         errors++;
         $display("FAIL bp_count got %0d beats want 3", n_out);
      end
   endtask

   // ---------------------------------------------------------------
   task automatic test_clear_collision();
      out_ready = 1'b1;
      set_beat(1'b1, 3'd7, 1'b1, 8'h0F, 8'h00);
      @(negedge clk);
      set_beat(1'b0, 3'd0, 1'b0, '0, '0);
      repeat (3) @(negedge clk);
      checks++;
      if (acc_q !== 8'h0F) begin
         errors++;
         $display("FAIL collision_setup got acc=%h want 0F", acc_q);
      end
      set_beat(1'b1, 3'd1, 1'b1, 8'hF0, 8'h00);
      @(negedge clk);
      set_beat(1'b0, 3'd0, 1'b0, '0, '0);
      acc_clr = 1'b1;
      @(negedge clk);
      acc_clr = 1'b0;
      checks++;
      if ({out_valid, out_data, acc_q} !== {1'b1, 8'hFF, 8'h00}) begin
         errors++;
         $display("FAIL clear_collision got v=%b d=%h acc=%h want v=1 d=FF acc=00",
                  out_valid, out_data, acc_q);
      end
      @(negedge clk);
   endtask

   // ---------------------------------------------------------------
   task automatic test_async_reset();
      out_ready = 1'b0;
      set_beat(1'b1, 3'd5, 1'b1, 8'h5A, 8'h00);
      @(negedge clk);
      set_beat(1'b1, 3'd1, 1'b0, 8'h81, 8'h18);
      @(negedge clk);
      set_beat(1'b0, 3'd0, 1'b0, '0, '0);
      checks++;
      if ({out_valid, in_ready, acc_q} !== {1'b1, 1'b0, 8'h5A}) begin
         errors++;
         $display("FAIL areset_preload got v=%b rdy=%b acc=%h want v=1 rdy=0 acc=5A",
                  out_valid, in_ready, acc_q);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, out_data, out_zero, out_ones, out_par, acc_q, in_ready} !==
          {1'b0, 8'h00, 3'b000, 8'h00, 1'b1}) begin
         errors++;
         $display("FAIL areset_immediate got v=%b d=%h zop=%b%b%b acc=%h rdy=%b want all 0 rdy=1",
                  out_valid, out_data, out_zero, out_ones, out_par, acc_q, in_ready);
      end
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_stale cyc=%0d got v=%b d=%h want v=0", c, out_valid, out_data);
         end
      end
   endtask

   // ---------------------------------------------------------------
   typedef struct {
      logic [W-1:0] d;
      int           e;
   } beat_t;

   task automatic test_random();
      beat_t        q[$];
      beat_t        nb;
      logic [W-1:0] m_acc = '0;
      logic [W-1:0] d;
      logic         exp_v, exp_rdy, pop, take;
      int           n_cyc = 400;
      for (int c = 0; c < n_cyc + 12; c++) begin
         if (c < n_cyc) begin
            out_ready = ($urandom_range(0, 3) != 0);
            set_beat(($urandom_range(0, 3) != 0), 3'($urandom), 1'($urandom),
                     8'($urandom), 8'($urandom));
         end else begin
            out_ready = 1'b1;
            set_beat(1'b0, 3'd0, 1'b0, '0, '0);
         end
         #1;
         exp_v   = (q.size() > 0) && (q[0].e < ecount);
         exp_rdy = (q.size() < 2) || out_ready;
         checks++;
         if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL rand_in_ready cyc=%0d got %b want %b", c, in_ready, exp_rdy);
         end
         checks++;
         if (out_valid !== exp_v) begin
            errors++;
            $display("FAIL rand_out_valid cyc=%0d got %b want %b", c, out_valid, exp_v);
         end else if (exp_v) begin
            d = q[0].d;
            checks++;
            if ({out_data, out_zero, out_ones, out_par} !==
                {d, (d == 8'h00), (d == 8'hFF), ^d}) begin
               errors++;
               $display("FAIL rand_data cyc=%0d got d=%h zop=%b%b%b want d=%h",
                        c, out_data, out_zero, out_ones, out_par, d);
            end
         end
         pop  = exp_v && out_ready;
         take = in_valid && exp_rdy;
         if (pop) void'(q.pop_front());
         if (take) begin
            nb.d = ref_logic(in_op, in_a, in_acc ? m_acc : in_b);
            if (in_acc) m_acc = nb.d;
            nb.e = ecount + 1;
            q.push_back(nb);
         end
         @(negedge clk);
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL rand_drain got %0d beats left want 0", q.size());
      end
      checks++;
      if (acc_q !== m_acc) begin
         errors++;
         $display("FAIL rand_acc got %h want %h", acc_q, m_acc);
      end
   endtask

   // ---------------------------------------------------------------
   initial begin
      test_reset();
      test_op_sweep();
      test_flags();
      test_accumulate();
      test_back_pressure();
      test_clear_collision();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_logic_unit_pipe
`default_nettype wire
